// File: rtl/md_unit_if.sv
// Multiply/divide unit bus: launch request, operands, busy flag and HI/LO results.
interface md_unit_if;
  logic        Start;
  logic [2:0]  Op;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output Start, Op, A, B, input Busy, HI, LO);
  modport slave  (input Start, Op, A, B, output Busy, HI, LO);
endinterface

// File: rtl/md_unit.sv
// md_unit: multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO.
// Build option: define MD_DIV0_GUARD_EN to make a divide by zero leave HI/LO untouched
// (the unit still stays busy for DIV_CYCLES). Without it, x/0 gives LO=all ones, HI=A.
//
// state | meaning
// IDLE  | accepting Start; MTHI/MTLO write immediately
// RUN   | operation in flight, Busy=1, counter counting down to 1
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic       CLK,
  input logic       Reset,
  md_unit_if.slave  bus
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [2:0]  op_q;
  logic [31:0] a_q, b_q;
  logic [31:0] hi_q, lo_q;
  logic        busy_q;

  logic [63:0] a_ext, b_ext, prod;
  logic        a_neg, b_neg, is_div;
  logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag;
  logic [31:0] hi_d, lo_d;
  logic        wr_d;

  // Result datapath from latched operands; only sampled on the final RUN edge.
  always_comb begin
    is_div = (op_q == OP_DIV) || (op_q == OP_DIVU);
    // Multiply: extend to 64 bits; the low 64 bits of the product are exact for both signednesses.
    a_ext  = (op_q == OP_MULT) ? {{32{a_q[31]}}, a_q} : {32'b0, a_q};
    b_ext  = (op_q == OP_MULT) ? {{32{b_q[31]}}, b_q} : {32'b0, b_q};
    prod   = a_ext * b_ext;
    // Divide on magnitudes so 0x80000000 / -1 needs no special overflow case.
    a_neg  = (op_q == OP_DIV) && a_q[31];
    b_neg  = (op_q == OP_DIV) && b_q[31];
    a_mag  = a_neg ? (32'd0 - a_q) : a_q;
    b_mag  = b_neg ? (32'd0 - b_q) : b_q;
    b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag  = a_mag / b_safe;
    r_mag  = a_mag % b_safe;
    if (is_div) begin
      if (b_q == 32'd0) begin
        lo_d = 32'hFFFF_FFFF;
        hi_d = a_q;
      end else begin
        lo_d = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        hi_d = a_neg ? (32'd0 - r_mag) : r_mag;
      end
    end else begin
      lo_d = prod[31:0];
      hi_d = prod[63:32];
    end
`ifdef MD_DIV0_GUARD_EN
    wr_d = !(is_div && (b_q == 32'd0));
`else
    wr_d = 1'b1;
`endif
  end

  // Control FSM with registered Busy and HI/LO.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      op_q    <= 3'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.Start) begin
            case (bus.Op)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                op_q    <= bus.Op;
                a_q     <= bus.A;
                b_q     <= bus.B;
                cnt_q   <= bus.Op[1] ? DIV_CNT : MULT_CNT;
                busy_q  <= 1'b1;
                state_q <= RUN;
              end
              OP_MTHI: hi_q <= bus.A;
              OP_MTLO: lo_q <= bus.A;
              default: ;
            endcase
          end
        end
        RUN: begin
          // Start is deliberately ignored here, including on the terminal edge.
          if (cnt_q <= 4'd1) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= 4'd0;
            if (wr_d) begin
              hi_q <= hi_d;
              lo_q <= lo_d;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= 4'd0;
        end
      endcase
    end
  end

  assign bus.Busy = busy_q;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, busy cycles for MULT/MULTU (legal 1..15).
REQ-002 SHALL have parameter DIV_CYCLES, default 10, busy cycles for DIV/DIVU (legal 1..15).
REQ-003 SHALL have port CLK  input  1  sole clock; all state changes on posedge CLK.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port Start  input  1  launch operation given by Op this cycle.
REQ-006 SHALL have port Op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 no-op.
REQ-007 SHALL have port A  input  32  operand 1 (GRF RD1 / rs).
REQ-008 SHALL have port B  input  32  operand 2 (GRF RD2 / rt).
REQ-009 SHALL have port Busy  output  1  operation in flight; new Start ignored.
REQ-010 SHALL have port HI  output  32  HI register, read by MFHI, result routed to GRF WD.
REQ-011 SHALL have port LO  output  32  LO register, read by MFLO, result routed to GRF WD.

Function
REQ-012 SHALL implement FSM states IDLE and RUN; IDLE->RUN on Start with Op 000..011; RUN->IDLE when counter reaches 1.
REQ-013 SHALL latch A, B and Op at the Start edge; later changes on A/B/Op SHALL not affect the result.
REQ-014 SHALL assert Busy from the cycle after the Start edge for exactly MULT_CYCLES or DIV_CYCLES cycles.
REQ-015 SHALL update HI/LO at the same edge that deasserts Busy; HI/LO SHALL hold old values while Busy=1.
REQ-016 MULT SHALL compute signed 64-bit A*B, MULTU unsigned; HI=product[63:32], LO=product[31:0].
REQ-017 DIV SHALL compute signed quotient truncated toward zero into LO, remainder with sign of dividend into HI.
REQ-018 DIVU SHALL compute unsigned quotient into LO, remainder into HI.
REQ-019 DIV 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0x00000000.
REQ-020 MTHI/MTLO with Start and Busy=0 SHALL write A into HI/LO at that edge, with no Busy cycle.
REQ-021 Start while Busy=1 SHALL be ignored entirely (no restart, no MTHI/MTLO write).
REQ-022 Start with Op 110/111 SHALL change no state.
REQ-023 Start in the cycle Busy deasserts (Busy=1 sampled) SHALL be ignored; Start the next cycle SHALL be accepted.
REQ-024 HI and LO SHALL be driven directly from registers (no combinational path from A/B/Op).

Reset
REQ-025 Reset low SHALL immediately force state IDLE, Busy=0, HI=0, LO=0, counter=0, independent of CLK.
REQ-026 Reset mid-operation SHALL abort it; no HI/LO update SHALL occur after Reset release.
REQ-027 First accepted Start SHALL be the first posedge with Reset high.

Configuration
REQ-028 Macro MD_DIV0_GUARD_EN defined: DIV/DIVU with B=0 SHALL still run DIV_CYCLES busy cycles but leave HI/LO unchanged.
REQ-029 Macro MD_DIV0_GUARD_EN undefined: DIV/DIVU with B=0 SHALL write LO=0xFFFFFFFF, HI=A after DIV_CYCLES.

Verification
REQ-030 MULT A=0xFFFFFFFE (-2), B=3 -> Busy 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-031 MULTU A=0xFFFFFFFF, B=2 -> after 5 cycles HI=0x00000001, LO=0xFFFFFFFE.
REQ-032 DIV A=0xFFFFFFF9 (-7), B=2 -> Busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF; Start MTLO at cycle 3 ignored.
REQ-033 MTHI A=0x12345678 then MTLO A=0x9ABCDEF0 on consecutive cycles -> HI=0x12345678, LO=0x9ABCDEF0, Busy never 1.
REQ-034 DIVU A=100, B=0 -> guard on: HI/LO unchanged; guard off: LO=0xFFFFFFFF, HI=0x00000064.
REQ-035 MULT started, Reset pulsed low at busy cycle 2 -> Busy=0, HI=LO=0 at once and remain 0 after release.
